inst_fetch_unit: RTL and testbench

Fetch stage of the multi-cycle CPU. Owns the word-addressed program counter, drives o_pc into the PC incrementer and takes back its incremented result. Runs the instruction-memory request/ready handshake, latches the fetched instruction into the IR and applies control-unit redirects (branch/jump). Sits between the control unit, the PC incrementer and instruction memory.

---
 rtl/inst_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the word-addressed PC, runs the instruction-memory
// request/ready handshake, latches the fetched word into the IR and applies
// branch/jump redirects from the control unit.
//
// Handshake: o_imem_req rises the cycle after an accepted i_fetch_req and
// stays high, with o_imem_addr stable, until a cycle in which i_imem_ready
// is high (that cycle's i_imem_rdata is captured) or until MAX_WAIT
// consecutive not-ready cycles have passed (timeout -> FAULT).
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_req,
    input  logic [31:0] i_pc_plus,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_ir,
    output logic        o_ir_valid,
    output logic        o_busy,
    output logic        o_fault,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FAULT = 2'd2
    } state_e;

    // Counter only ever needs to reach MAX_WAIT-1.
    localparam int          CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_pc_q, pend_pc_d;

    logic          timeout;

    // Last allowed not-ready cycle of a request.
    assign timeout = (cnt_q == CNT_LAST) && !i_imem_ready;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ready wins over timeout in the final allowed cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!i_redirect_valid && i_fetch_req) state_d = S_REQ;
            end
            S_REQ: begin
                if (i_imem_ready) state_d = S_IDLE;
                else if (timeout) state_d = S_FAULT;
            end
            S_FAULT: begin
                if (i_redirect_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; every output is a register loaded here.
    always_comb begin
        pc_d       = pc_q;
        addr_d     = addr_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        req_d      = req_q;
        busy_d     = busy_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_redirect_valid) begin
                    // Redirect has priority; a simultaneous fetch is dropped.
                    pc_d = i_redirect_pc;
                end else if (i_fetch_req) begin
                    addr_d = pc_q;
                    req_d  = 1'b1;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            S_REQ: begin
                if (i_imem_ready) begin
                    ir_d       = i_imem_rdata;
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
                    busy_d     = 1'b0;
                    pend_d     = 1'b0;
                    // A redirect this cycle beats one stored earlier.
                    if (i_redirect_valid) pc_d = i_redirect_pc;
                    else if (pend_q)      pc_d = pend_pc_q;
                    else                  pc_d = i_pc_plus;
                end else begin
                    if (i_redirect_valid) begin
                        pend_d    = 1'b1;
                        pend_pc_d = i_redirect_pc;
                    end
                    if (timeout) begin
                        // Abandon the fetch; any stored target is discarded.
                        req_d   = 1'b0;
                        busy_d  = 1'b0;
                        fault_d = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                if (i_redirect_valid) begin
                    pc_d    = i_redirect_pc;
                    fault_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any fetch in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign o_pc        = pc_q;
    assign o_imem_addr = addr_q;
    assign o_ir        = ir_q;
    assign o_ir_valid  = ir_valid_q;
    assign o_imem_req  = req_q;
    assign o_busy      = busy_q;
    assign o_fault     = fault_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by randomized
// fetches, each predicted at transaction level (address used, word captured,
// next PC, fault or not).
module tb_inst_fetch_unit;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] pc_plus;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic [31:0] o_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] o_ir;
    logic        o_ir_valid;
    logic        o_busy;
    logic        o_fault;
    logic [1:0]  o_state;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int busy_cyc = 0;

    // Transaction-level model state.
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_fault;

    inst_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_fetch_req      (fetch_req),
        .i_pc_plus        (pc_plus),
        .i_redirect_valid (redir_v),
        .i_redirect_pc    (redir_pc),
        .o_pc             (o_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_ready     (ready),
        .i_imem_rdata     (rdata),
        .o_ir             (o_ir),
        .o_ir_valid       (o_ir_valid),
        .o_busy           (o_busy),
        .o_fault          (o_fault),
        .o_state          (o_state)
    );

    // External PC incrementer.
    assign pc_plus = o_pc + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_ir_valid) pulses++;
        if (o_busy) busy_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_pc"}, o_pc, 32'h0);
        chk({pfx, "_addr"}, o_imem_addr, 32'h0);
        chk({pfx, "_ir"}, o_ir, 32'h0);
        chk({pfx, "_ir_valid"}, {31'b0, o_ir_valid}, 32'h0);
        chk({pfx, "_req"}, {31'b0, o_imem_req}, 32'h0);
        chk({pfx, "_busy"}, {31'b0, o_busy}, 32'h0);
        chk({pfx, "_fault"}, {31'b0, o_fault}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_pc = 32'h0; m_ir = 32'h0; m_fault = 1'b0;
        tick();
    endtask

    task automatic idle_tick();
        tick();
        chk("idle_ir_valid", {31'b0, o_ir_valid}, 32'h0);
        chk("idle_req", {31'b0, o_imem_req}, 32'h0);
        chk("idle_fault", {31'b0, o_fault}, {31'b0, m_fault});
    endtask

    // One fetch: memory becomes ready in REQ cycle w (w >= MAX_WAIT means
    // never); a directed redirect in REQ cycle rcyc; optional random ones.
    task automatic run_fetch(input int w, input logic [31:0] data, input int rcyc,
                             input logic [31:0] rtgt, input bit rnd);
        logic [31:0] exp_addr;
        logic [31:0] tgt;
        bit          have;
        bit          done;
        exp_addr = m_pc;
        have = 1'b0;
        done = 1'b0;
        tgt  = 32'h0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("first_req_ir_valid", {31'b0, o_ir_valid}, 32'h0);
        for (int k = 0; k < MAX_WAIT && !done; k++) begin
            chk("req_hold", {31'b0, o_imem_req}, 32'h1);
            chk("addr_hold", o_imem_addr, exp_addr);
            chk("busy_hold", {31'b0, o_busy}, 32'h1);
            ready = (k == w);
            rdata = ready ? data : $urandom;
            fetch_req = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            redir_v = 1'b0;
            if (k == rcyc) begin
                redir_v = 1'b1; redir_pc = rtgt;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                redir_v = 1'b1; redir_pc = $urandom;
            end
            if (redir_v) begin have = 1'b1; tgt = redir_pc; end
            done = (k == w);
            tick();
            ready = 1'b0; redir_v = 1'b0; fetch_req = 1'b0;
        end
        if (done) begin
            m_ir = data;
            m_pc = have ? tgt : m_pc + 32'd1;
            chk("done_ir_valid", {31'b0, o_ir_valid}, 32'h1);
            chk("done_ir", o_ir, m_ir);
            chk("done_pc", o_pc, m_pc);
            chk("done_req", {31'b0, o_imem_req}, 32'h0);
            chk("done_busy", {31'b0, o_busy}, 32'h0);
            chk("done_fault", {31'b0, o_fault}, 32'h0);
        end else begin
            m_fault = 1'b1;
            chk("to_fault", {31'b0, o_fault}, 32'h1);
            chk("to_req", {31'b0, o_imem_req}, 32'h0);
            chk("to_busy", {31'b0, o_busy}, 32'h0);
            chk("to_pc", o_pc, m_pc);
            chk("to_ir", o_ir, m_ir);
            chk("to_ir_valid", {31'b0, o_ir_valid}, 32'h0);
        end
    endtask

    task automatic recover(input logic [31:0] tgt);
        redir_v = 1'b1; redir_pc = tgt;
        tick();
        redir_v = 1'b0;
        m_pc = tgt; m_fault = 1'b0;
        chk("rec_fault", {31'b0, o_fault}, 32'h0);
        chk("rec_pc", o_pc, m_pc);
        chk("rec_req", {31'b0, o_imem_req}, 32'h0);
    endtask

    initial begin
        int p0;
        int b0;
        rst_n = 1'b0; fetch_req = 1'b0; redir_v = 1'b0; redir_pc = 32'h0;
        ready = 1'b0; rdata = 32'h0;
        m_pc = 32'h0; m_ir = 32'h0; m_fault = 1'b0;
        tick();
        chk_reset("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Single fetch with memory ready in the first REQ cycle.
        run_fetch(0, 32'h2002_0005, -1, 32'h0, 1'b0);
        chk("single_addr", o_imem_addr, 32'h0);
        chk("single_pc", o_pc, 32'h1);
        idle_tick();

        // Three back-to-back fetches, two wait cycles each.
        do_reset();
        p0 = pulses; b0 = busy_cyc;
        for (int i = 0; i < 3; i++) run_fetch(2, $urandom, -1, 32'h0, 1'b0);
        idle_tick();
        chk("b2b_pc", o_pc, 32'h3);
        chk("b2b_pulses", pulses - p0, 32'd3);
        chk("b2b_busy_cycles", busy_cyc - b0, 32'd9);

        // Redirect while memory stalls; next fetch uses the target.
        run_fetch(3, 32'hCAFE_0001, 1, 32'h40, 1'b0);
        chk("redir_pc", o_pc, 32'h40);
        run_fetch(0, 32'hCAFE_0002, -1, 32'h0, 1'b0);
        chk("redir_next_pc", o_pc, 32'h41);
        idle_tick();

        // Redirect and fetch request in the same IDLE cycle.
        redir_v = 1'b1; redir_pc = 32'h10; fetch_req = 1'b1;
        tick();
        redir_v = 1'b0; fetch_req = 1'b0; m_pc = 32'h10;
        chk("same_pc", o_pc, 32'h10);
        chk("same_req0", {31'b0, o_imem_req}, 32'h0);
        tick();
        chk("same_req1", {31'b0, o_imem_req}, 32'h0);
        chk("same_busy", {31'b0, o_busy}, 32'h0);

        // Timeout with a stored redirect that must be discarded.
        run_fetch(MAX_WAIT, 32'h0, 1, 32'h77, 1'b0);
        fetch_req = 1'b1;
        tick();
        tick();
        fetch_req = 1'b0;
        chk("fault_hold", {31'b0, o_fault}, 32'h1);
        chk("fault_no_req", {31'b0, o_imem_req}, 32'h0);
        recover(32'h80);
        idle_tick();
        // Ready in the final allowed cycle completes normally.
        run_fetch(MAX_WAIT - 1, 32'h1234_5678, -1, 32'h0, 1'b0);
        chk("last_cycle_pc", o_pc, 32'h81);
        idle_tick();

        // Asynchronous reset in the middle of a request.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        #3;
        rst_n = 1'b0; ready = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        chk_reset("arst");
        tick();
        chk("arst_no_pulse", {31'b0, o_ir_valid}, 32'h0);
        rst_n = 1'b1; ready = 1'b0;
        m_pc = 32'h0; m_ir = 32'h0; m_fault = 1'b0;
        tick();
        chk("arst_after_ir_valid", {31'b0, o_ir_valid}, 32'h0);
        chk("arst_after_req", {31'b0, o_imem_req}, 32'h0);

        // Randomized fetches with random stalls, redirects and timeouts.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                redir_v = 1'b1; redir_pc = $urandom; fetch_req = 1'($urandom_range(0, 1));
                tick();
                redir_v = 1'b0; fetch_req = 1'b0;
                m_pc = redir_pc;
                chk("rnd_idle_redir_pc", o_pc, m_pc);
                chk("rnd_idle_redir_req", {31'b0, o_imem_req}, 32'h0);
            end
            run_fetch($urandom_range(0, MAX_WAIT + 1), $urandom, -1, 32'h0, 1'b1);
            if (m_fault) recover($urandom);
        end
        idle_tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
